ccff_loader: RTL and testbench

Wishbone-slave initiator for the FPGA fabric configuration chain. It is the driving end of the chain whose ccff_head, prog_clk and prog_reset the fabric consumes, and whose ccff_tail it emits.
- Firmware pushes 32-bit bitstream words over Wishbone.
- The block serialises them LSB-first onto ccff_head under a divided prog_clk.
- It optionally captures ccff_tail for readback.
- It sits beside fpga_top in the user wrapper, behind the wrapper's stb address decode.

---
 rtl/ccff_loader.sv | 191 +++++++++++++++++++
 tb/tb_ccff_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// Wishbone-driven initiator for the fabric configuration chain: serialises bitstream words LSB-first onto ccff_head.
// Define CCFF_READBACK_EN to capture ccff_tail into a readback word readable at DATA.
module ccff_loader #(
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk,
  output logic        prog_reset,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        done_irq
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] clkdiv;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] remain;
  logic [31:0]      hold;
  logic [31:0]      shifter;
  logic             hold_full;
  logic             underrun;
  logic             done;
  logic [4:0]       bits_done;
  logic [31:0]      rb_data;
  logic [31:0]      rdata;

  logic req, accept, busy, rise;
  logic wr_ctrl, wr_data, wr_clkdiv, wr_remain;

  assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  // A DATA write against a full hold register stalls until the shifter drains it.
  assign accept    = req & ~(wbs_we_i & (wbs_adr_i[4:2] == 3'd2) & hold_full);
  assign wr_ctrl   = accept & wbs_we_i & (wbs_adr_i[4:2] == 3'd0);
  assign wr_data   = accept & wbs_we_i & (wbs_adr_i[4:2] == 3'd2);
  assign wr_clkdiv = accept & wbs_we_i & (wbs_adr_i[4:2] == 3'd3);
  assign wr_remain = accept & wbs_we_i & (wbs_adr_i[4:2] == 3'd4);
  assign busy      = (state != S_IDLE);
  assign rise      = (state == S_SETUP) && (div_cnt == '0);

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[4:2])
      3'd0:    rdata = {30'd0, prog_reset, 1'b0};
      3'd1:    rdata = {28'd0, done, underrun, hold_full, busy};
      3'd2:    rdata = rb_data;
      3'd3:    rdata = 32'(clkdiv);
      3'd4:    rdata = 32'(remain);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      prog_clk   <= 1'b0;
      prog_reset <= 1'b1;
      ccff_head  <= 1'b0;
      done_irq   <= 1'b0;
      state      <= S_IDLE;
      clkdiv     <= DIV_W'(DEFAULT_DIV);
      div_cnt    <= '0;
      remain     <= '0;
      hold_full  <= 1'b0;
      underrun   <= 1'b0;
      done       <= 1'b0;
      bits_done  <= '0;
    end else begin
      wbs_ack_o <= accept;
      done_irq  <= 1'b0;
      if (accept) wbs_dat_o <= wbs_we_i ? '0 : rdata;

      case (state)
        S_IDLE: ;
        S_LOAD: begin
          if (hold_full) begin
            ccff_head <= hold[0];
            hold_full <= 1'b0;
            div_cnt   <= clkdiv;
            state     <= S_SETUP;
          end else begin
            underrun <= 1'b1;
          end
        end
        S_SETUP: begin
          if (div_cnt == '0) begin
            prog_clk  <= 1'b1;
            remain    <= remain - CNT_W'(1);
            bits_done <= bits_done + 5'd1;
            div_cnt   <= clkdiv;
            state     <= S_HIGH;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (div_cnt == '0) begin
            prog_clk <= 1'b0;
            if (remain == '0) begin
              state <= S_DONE;
            end else if (bits_done == '0) begin
              state <= S_LOAD;
            end else begin
              // Head changes on the falling edge, leaving a full half-period either side of each rise.
              ccff_head <= shifter[0];
              div_cnt   <= clkdiv;
              state     <= S_SETUP;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          done_irq <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_data) hold_full <= 1'b1;
      if (wr_clkdiv && !busy) clkdiv <= wbs_dat_i[DIV_W-1:0];
      if (wr_remain && !busy) remain <= wbs_dat_i[CNT_W-1:0];

      if (wr_ctrl) begin
        prog_reset <= wbs_dat_i[1];
        if (wbs_dat_i[2]) begin
          state     <= S_IDLE;
          prog_clk  <= 1'b0;
          hold_full <= 1'b0;
          remain    <= '0;
          // An abort landing on the DONE cycle must not report completion.
          done      <= done;
          done_irq  <= 1'b0;
        end else if (wbs_dat_i[0] && !busy) begin
          underrun  <= 1'b0;
          done      <= 1'b0;
          bits_done <= '0;
          state     <= (remain != '0) ? S_LOAD : S_DONE;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_data) hold <= wbs_dat_i;
    if (state == S_LOAD && hold_full) shifter <= hold;
    else if (rise)                    shifter <= shifter >> 1;
  end

`ifdef CCFF_READBACK_EN
  logic [31:0] rb_shift;
  logic [31:0] rb_word;
  logic [31:0] rb_next;

  assign rb_next = {ccff_tail, rb_shift[31:1]};
  assign rb_data = rb_word;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rb_shift <= '0;
      rb_word  <= '0;
    end else if (rise) begin
      rb_shift <= rb_next;
      if (bits_done == 5'd31) rb_word <= rb_next;
    end else if (state == S_DONE && bits_done != '0) begin
      // Partial word: slide captured bits down so the first one sits at bit 0.
      rb_word <= rb_shift >> (6'd32 - {1'b0, bits_done});
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
`endif

  logic unused_bus;
  assign unused_bus = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};
endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: bus reads and prog_clk rises are checked by monitors against queued expectations.
module tb_ccff_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, pclk, preset, head, tail, irq;
  logic [31:0] rdat;
  logic [31:0] chain = '0;

  always #5 clk = ~clk;

  // Fabric stand-in: a 32-stage chain clocked by prog_clk.
  assign tail = chain[0];
  always @(posedge pclk) chain <= {head, chain[31:1]};

  ccff_loader dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .prog_clk(pclk), .prog_reset(preset),
    .ccff_head(head), .ccff_tail(tail), .done_irq(irq)
  );

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    int          id;
  } rsp_t;

  rsp_t rq[$];
  bit   hq[$];
  int   checks = 0, errors = 0;
  int   cycles = 0, rises = 0, irqs = 0, last_rise = 0, last_period = 0;
  logic pclk_d = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cycles++;
  end

  initial forever begin
    @(negedge clk);
    if (ack) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard");
      end else begin
        rsp_t r;
        r = rq.pop_front();
        if (r.chk) chk($sformatf("read_reg%0d", r.id), rdat, r.exp);
      end
    end
    if (irq) irqs++;
    if (pclk && !pclk_d) begin
      rises++;
      last_period = cycles - last_rise;
      last_rise   = cycles;
      if (hq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rise: rise %0d with no expected bit", rises);
      end else begin
        bit b;
        b = hq.pop_front();
        chk($sformatf("head_bit%0d", rises), 32'(head), 32'(b));
      end
    end
    pclk_d = pclk;
  end

  task automatic bus(input bit w, input int r, input logic [31:0] d,
                     input logic [31:0] e, input bit c, output int lat);
    rsp_t it;
    it.exp = e; it.chk = c; it.id = r;
    rq.push_back(it);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = 32'(r) << 2; dat = d;
    lat = 0;
    while (!ack && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    if (!ack) begin
      checks++; errors++;
      $display("FAIL bus_timeout reg%0d: no ack after %0d cycles, required ack", r, lat);
      void'(rq.pop_back());
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    int lat;
    bus(1'b1, r, d, '0, 1'b0, lat);
  endtask

  task automatic rd(input int r, input logic [31:0] e);
    int lat;
    bus(1'b0, r, '0, e, 1'b1, lat);
  endtask

  task automatic push_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) hq.push_back(w[i]);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rises < target) begin
      checks++; errors++;
      $display("FAIL rise_timeout: rises %0d required %0d", rises, target);
    end
  endtask

  task automatic wait_irq(input int target);
    int n = 0;
    while (irqs < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (irqs < target) begin
      checks++; errors++;
      $display("FAIL irq_timeout: irqs %0d required %0d", irqs, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_r, base_i, lat2, lat3, n;
    logic [31:0] rb_exp;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_prog_reset", 32'(preset), 32'd1);
    chk("rst_prog_clk", 32'(pclk), 32'd0);
    chk("rst_head", 32'(head), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(0, 32'h2);
    rd(1, 32'h0);
    rd(2, 32'h0);
    rd(3, 32'h3);
    rd(4, 32'h0);
    rd(5, 32'h0);
    wr(0, 32'h0);
    chk("prst_release", 32'(preset), 32'd0);

    // 8-bit transfer of 0xA5 at the fastest divider
    wr(3, 32'h0);
    wr(4, 32'd8);
    push_word(32'hA5, 8);
    wr(2, 32'hA5);
    base_r = rises; base_i = irqs;
    wr(0, 32'h1);
    wait_irq(base_i + 1);
    chk("a5_rises", 32'(rises - base_r), 32'd8);
    chk("a5_period", 32'(last_period), 32'd2);
    repeat (3) @(negedge clk);
    chk("a5_irq_once", 32'(irqs - base_i), 32'd1);
    rd(1, 32'h8);
    rd(4, 32'h0);

    // Double buffering and bus stall on a full hold register
    wr(4, 32'd96);
    push_word(32'hFFFF_FFFF, 32);
    push_word(32'h0000_0000, 32);
    push_word(32'h0000_FFFF, 32);
    wr(2, 32'hFFFF_FFFF);
    base_r = rises; base_i = irqs;
    wr(0, 32'h1);
    bus(1'b1, 2, 32'h0000_0000, '0, 1'b0, lat2);
    bus(1'b1, 2, 32'h0000_FFFF, '0, 1'b0, lat3);
    chk("nostall_lat", 32'(lat2), 32'd2);
    chk("stall_seen", 32'(lat3 > 20), 32'd1);
    wait_irq(base_i + 1);
    chk("dbl_rises", 32'(rises - base_r), 32'd96);
    rd(1, 32'h8);

    // Underrun: 40 bits with only one word supplied up front
    wr(4, 32'd40);
    push_word(32'h0000_FFFF, 32);
    wr(2, 32'h0000_FFFF);
    base_r = rises; base_i = irqs;
    wr(0, 32'h1);
    wait_rises(base_r + 32);
    repeat (10) @(negedge clk);
    chk("underrun_pclk_low", 32'(pclk), 32'd0);
    chk("underrun_stalled", 32'(rises - base_r), 32'd32);
    rd(1, 32'h5);
    rd(4, 32'd8);
    wr(3, 32'd5);
    rd(3, 32'd0);
    push_word(32'h3C, 8);
    wr(2, 32'h3C);
    wait_irq(base_i + 1);
    chk("underrun_rises", 32'(rises - base_r), 32'd40);
    rd(1, 32'hC);

    // Abort mid-word with a slower divider
    wr(3, 32'd1);
    wr(4, 32'd32);
    push_word(32'hDEAD_BEEF, 32);
    wr(2, 32'hDEAD_BEEF);
    base_r = rises; base_i = irqs;
    wr(0, 32'h1);
    wait_rises(base_r + 5);
    chk("div1_period", 32'(last_period), 32'd4);
    wr(0, 32'h4);
    chk("abort_pclk", 32'(pclk), 32'd0);
    hq.delete();
    base_r = rises;
    rd(4, 32'h0);
    rd(1, 32'h0);
    repeat (20) @(negedge clk);
    chk("abort_no_rises", 32'(rises - base_r), 32'd0);
    chk("abort_no_irq", 32'(irqs - base_i), 32'd0);

    // Readback through the 32-stage chain
    wr(3, 32'd0);
    wr(4, 32'd64);
    push_word(32'h1234_5678, 32);
    push_word(32'h0000_0000, 32);
    wr(2, 32'h1234_5678);
    base_i = irqs;
    wr(0, 32'h1);
    wr(2, 32'h0000_0000);
    wait_irq(base_i + 1);
`ifdef CCFF_READBACK_EN
    rb_exp = 32'h1234_5678;
`else
    rb_exp = 32'h0;
`endif
    rd(2, rb_exp);

    // Asynchronous reset while prog_clk is high
    wr(4, 32'd32);
    push_word(32'hFFFF_FFFF, 32);
    wr(2, 32'hFFFF_FFFF);
    wr(0, 32'h1);
    n = 0;
    while (!pclk && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pclk_seen_high", 32'(pclk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pclk", 32'(pclk), 32'd0);
    chk("arst_prog_reset", 32'(preset), 32'd1);
    hq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(4, 32'h0);
    rd(0, 32'h2);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(rq.size()), 32'd0);
    chk("head_queue_empty", 32'(hq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
